warp_scheduler: RTL and testbench

- Front end of the issue path: chooses one eligible warp per cycle round-robin, pops its instruction-buffer head and registers it as the selected packet for the Issue stage.
- Tracks per-warp lifecycle (idle / active / at barrier) from Issue-stage sync/exit feedback.
- Releases barriers when every live warp has arrived.

---
 rtl/warp_scheduler_if.sv | 28 ++
 rtl/warp_scheduler.sv | 166 ++++++++++++++++
 tb/tb_warp_scheduler.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/warp_scheduler_if.sv
// Issue-path bundle between instruction buffers, scheduler and Issue stage.
// slave = scheduler side, master = buffer/Issue side driving the _i signals.
interface warp_scheduler_if #(
    parameter int NUM_WARP     = 8,
    parameter int NUM_WARP_LOG = 3,
    parameter int PACKET_W     = 64
) ();
    logic [NUM_WARP-1:0]          ibufValid_i;
    logic [NUM_WARP*PACKET_W-1:0] ibufPacket_i;
    logic [NUM_WARP-1:0]          ibufPop_o;
    logic                         stall_i;
    logic [NUM_WARP_LOG-1:0]      issuedWarp_i;
    logic                         issuedSync_i;
    logic                         issuedExit_i;
    logic [NUM_WARP_LOG-1:0]      selectedWarp_o;
    logic                         selectedPacketValid_o;
    logic [PACKET_W-1:0]          selectedPacket_o;

    modport master (
        output ibufValid_i, ibufPacket_i, stall_i, issuedWarp_i, issuedSync_i, issuedExit_i,
        input  ibufPop_o, selectedWarp_o, selectedPacketValid_o, selectedPacket_o
    );

    modport slave (
        input  ibufValid_i, ibufPacket_i, stall_i, issuedWarp_i, issuedSync_i, issuedExit_i,
        output ibufPop_o, selectedWarp_o, selectedPacketValid_o, selectedPacket_o
    );
endinterface

// File: rtl/warp_scheduler.sv
// Round-robin warp selector with per-warp IDLE/ACTIVE/BARRIER lifecycle; 1-cycle head-to-output latency.
// stall_i holds the output register, forces pops low and ignores feedback. WARP_SCHED_PERF_EN adds counters.
module warp_scheduler #(
    parameter int NUM_WARP     = 8,
    parameter int NUM_WARP_LOG = 3,
    parameter int PACKET_W     = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    warp_scheduler_if.slave         bus,
    input  logic [NUM_WARP-1:0]     warpStall_i,
    input  logic                    launch_i,
    input  logic [NUM_WARP-1:0]     launchMask_i,
`ifdef WARP_SCHED_PERF_EN
    output logic [31:0]             issueCount_o,
    output logic [31:0]             idleCount_o,
`endif
    output logic                    barrierRelease_o,
    output logic                    allExited_o
);
    typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_BARRIER} wstate_e;

    wstate_e                 state_q [NUM_WARP];
    wstate_e                 state_d [NUM_WARP];
    logic [NUM_WARP_LOG-1:0] ptr_q, ptr_d;
    logic [NUM_WARP_LOG-1:0] sel_warp_q, sel_warp_d;
    logic                    sel_vld_q, sel_vld_d;
    logic [PACKET_W-1:0]     sel_pkt_q, sel_pkt_d;
    logic                    rel_q, rel_d;
    logic                    allx_q, allx_d;

    logic [NUM_WARP-1:0]     elig;
    logic                    found;
    logic [NUM_WARP_LOG-1:0] win;
    logic [NUM_WARP_LOG-1:0] rr_idx;
    logic                    accept;
    logic                    any_live;
    logic                    any_active_fb;

    // The in-flight warp stays blocked until its sync/exit feedback has been applied.
    always_comb begin
        for (int w = 0; w < NUM_WARP; w++) begin
            elig[w] = (state_q[w] == W_ACTIVE) && bus.ibufValid_i[w] && !warpStall_i[w] &&
                      !(sel_vld_q && (sel_warp_q == NUM_WARP_LOG'(w)));
        end
    end

    always_comb begin
        found  = 1'b0;
        win    = ptr_q;
        rr_idx = ptr_q;
        for (int i = 1; i <= NUM_WARP; i++) begin
            rr_idx = NUM_WARP_LOG'((int'(ptr_q) + i) % NUM_WARP);
            if (!found && elig[rr_idx]) begin
                found = 1'b1;
                win   = rr_idx;
            end
        end
    end

    assign bus.ibufPop_o = (found && !bus.stall_i) ? (NUM_WARP'(1) << win) : '0;

    // Lifecycle next state: launch, then accepted feedback, then barrier release on the result.
    always_comb begin
        accept        = sel_vld_q && !bus.stall_i;
        any_live      = 1'b0;
        any_active_fb = 1'b0;
        rel_d         = 1'b0;
        for (int w = 0; w < NUM_WARP; w++) begin
            state_d[w] = state_q[w];
            unique case (state_q[w])
                W_IDLE: begin
                    if (launch_i && launchMask_i[w]) state_d[w] = W_ACTIVE;
                end
                W_ACTIVE: begin
                    if (accept && (bus.issuedWarp_i == NUM_WARP_LOG'(w))) begin
                        if (bus.issuedExit_i)      state_d[w] = W_IDLE;
                        else if (bus.issuedSync_i) state_d[w] = W_BARRIER;
                    end
                end
                W_BARRIER: state_d[w] = W_BARRIER;
                default:   state_d[w] = W_IDLE;
            endcase
            if (state_d[w] != W_IDLE)   any_live      = 1'b1;
            if (state_d[w] == W_ACTIVE) any_active_fb = 1'b1;
        end
        if (any_live && !any_active_fb) begin
            rel_d = 1'b1;
            for (int w = 0; w < NUM_WARP; w++) begin
                if (state_d[w] == W_BARRIER) state_d[w] = W_ACTIVE;
            end
        end
    end

    always_comb begin
        sel_vld_d  = sel_vld_q;
        sel_warp_d = sel_warp_q;
        sel_pkt_d  = sel_pkt_q;
        ptr_d      = ptr_q;
        if (!bus.stall_i) begin
            sel_vld_d = found;
            if (found) begin
                sel_warp_d = win;
                sel_pkt_d  = bus.ibufPacket_i[int'(win)*PACKET_W +: PACKET_W];
                ptr_d      = win;
            end
        end
        allx_d = !any_live && !sel_vld_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARP; w++) state_q[w] <= W_IDLE;
            ptr_q      <= NUM_WARP_LOG'(NUM_WARP - 1);
            sel_warp_q <= '0;
            sel_vld_q  <= 1'b0;
            sel_pkt_q  <= '0;
            rel_q      <= 1'b0;
            allx_q     <= 1'b1;
        end else begin
            for (int w = 0; w < NUM_WARP; w++) state_q[w] <= state_d[w];
            ptr_q      <= ptr_d;
            sel_warp_q <= sel_warp_d;
            sel_vld_q  <= sel_vld_d;
            sel_pkt_q  <= sel_pkt_d;
            rel_q      <= rel_d;
            allx_q     <= allx_d;
        end
    end

    assign bus.selectedWarp_o        = sel_warp_q;
    assign bus.selectedPacketValid_o = sel_vld_q;
    assign bus.selectedPacket_o      = sel_pkt_q;
    assign barrierRelease_o          = rel_q;
    assign allExited_o               = allx_q;

`ifdef WARP_SCHED_PERF_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] idle_cnt_q, idle_cnt_d;
    logic        any_active_q;

    always_comb begin
        any_active_q = 1'b0;
        for (int w = 0; w < NUM_WARP; w++) begin
            if (state_q[w] == W_ACTIVE) any_active_q = 1'b1;
        end
        issue_cnt_d = issue_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        if (!bus.stall_i && found)                 issue_cnt_d = issue_cnt_q + 32'd1;
        if (!bus.stall_i && any_active_q && !found) idle_cnt_d  = idle_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_cnt_q <= '0;
            idle_cnt_q  <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    assign issueCount_o = issue_cnt_q;
    assign idleCount_o  = idle_cnt_q;
`endif
endmodule

// File: tb/tb_warp_scheduler.sv
// Directed bench for warp_scheduler: expected selections are queued before each edge and checked after it.
module tb_warp_scheduler;
    localparam int NW  = 8;
    localparam int NWL = 3;
    localparam int PW  = 64;

    logic          clk;
    logic          reset;
    logic [NW-1:0] warpStall;
    logic          launch;
    logic [NW-1:0] launchMask;
    logic          barrierRelease;
    logic          allExited;
`ifdef WARP_SCHED_PERF_EN
    logic [31:0]   issueCount;
    logic [31:0]   idleCount;
`endif

    warp_scheduler_if #(.NUM_WARP(NW), .NUM_WARP_LOG(NWL), .PACKET_W(PW)) bus ();

    warp_scheduler #(.NUM_WARP(NW), .NUM_WARP_LOG(NWL), .PACKET_W(PW)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .warpStall_i      (warpStall),
        .launch_i         (launch),
        .launchMask_i     (launchMask),
`ifdef WARP_SCHED_PERF_EN
        .issueCount_o     (issueCount),
        .idleCount_o      (idleCount),
`endif
        .barrierRelease_o (barrierRelease),
        .allExited_o      (allExited)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        vld;
        logic [2:0]  warp;
        logic [63:0] pkt;
        logic        rel;
        logic        allx;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [7:0]  gen   = 8'd0;
    logic [63:0] last_pkt = '0;

    function automatic logic [63:0] pkt_of(input int w, input logic [7:0] g);
        logic [7:0] wb;
        wb = 8'(w);
        return {16'hC0DE, wb, g, 32'h0BAD_F00D};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_pkts();
        for (int w = 0; w < NW; w++) bus.ibufPacket_i[w*PW +: PW] = pkt_of(w, gen);
    endtask

    task automatic fb(input int w, input logic s, input logic e);
        bus.issuedWarp_i = 3'(w);
        bus.issuedSync_i = s;
        bus.issuedExit_i = e;
    endtask

    // Called at posedge+1 with inputs set; checks pop before the edge and registered outputs after it.
    task automatic cyc(input string tag, input logic [7:0] exp_pop, input logic exp_vld,
                       input int exp_warp, input logic exp_rel, input logic exp_allx);
        exp_t e;
        drive_pkts();
        #3;
        chk({tag, ".pop"}, 64'(bus.ibufPop_o), 64'(exp_pop));
        if (exp_vld && !bus.stall_i) last_pkt = pkt_of(exp_warp, gen);
        e.vld  = exp_vld;
        e.warp = 3'(exp_warp);
        e.pkt  = last_pkt;
        e.rel  = exp_rel;
        e.allx = exp_allx;
        sb.push_back(e);
        @(posedge clk);
        #1;
        gen++;
        e = sb.pop_front();
        chk({tag, ".vld"},  64'(bus.selectedPacketValid_o), 64'(e.vld));
        chk({tag, ".rel"},  64'(barrierRelease), 64'(e.rel));
        chk({tag, ".allx"}, 64'(allExited), 64'(e.allx));
        if (e.vld) begin
            chk({tag, ".warp"}, 64'(bus.selectedWarp_o), 64'(e.warp));
            chk({tag, ".pkt"},  bus.selectedPacket_o, e.pkt);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        launch     = 1'b0;
        launchMask = '0;
        bus.stall_i = 1'b0;
        fb(0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset            = 1'b0;
        warpStall        = '0;
        launch           = 1'b0;
        launchMask       = '0;
        bus.ibufValid_i  = 8'hFF;
        bus.ibufPacket_i = '0;
        bus.stall_i      = 1'b0;
        fb(0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("rst.vld",  64'(bus.selectedPacketValid_o), 64'd0);
        chk("rst.warp", 64'(bus.selectedWarp_o), 64'd0);
        chk("rst.pkt",  bus.selectedPacket_o, 64'd0);
        chk("rst.rel",  64'(barrierRelease), 64'd0);
        chk("rst.allx", 64'(allExited), 64'd1);
        chk("rst.pop",  64'(bus.ibufPop_o), 64'd0);
        reset = 1'b1;

        // Two active warps alternate 0,2,0,2
        launch = 1'b1; launchMask = 8'h05;
        cyc("t1.launch", 8'h00, 1'b0, 0, 1'b0, 1'b0);
        launch = 1'b0;
        cyc("t1.s0", 8'h01, 1'b1, 0, 1'b0, 1'b0);
        cyc("t1.s1", 8'h04, 1'b1, 2, 1'b0, 1'b0);
        cyc("t1.s2", 8'h01, 1'b1, 0, 1'b0, 1'b0);
        cyc("t1.s3", 8'h04, 1'b1, 2, 1'b0, 1'b0);

        // Single warp issues every other cycle
        do_reset();
        launch = 1'b1; launchMask = 8'h08;
        cyc("t2.launch", 8'h00, 1'b0, 0, 1'b0, 1'b0);
        launch = 1'b0;
        cyc("t2.s0", 8'h08, 1'b1, 3, 1'b0, 1'b0);
        cyc("t2.s1", 8'h00, 1'b0, 3, 1'b0, 1'b0);
        cyc("t2.s2", 8'h08, 1'b1, 3, 1'b0, 1'b0);
        cyc("t2.s3", 8'h00, 1'b0, 3, 1'b0, 1'b0);

        // Barrier between warps 0 and 1
        do_reset();
        launch = 1'b1; launchMask = 8'h03;
        cyc("t3.launch", 8'h00, 1'b0, 0, 1'b0, 1'b0);
        launch = 1'b0;
        cyc("t3.s0", 8'h01, 1'b1, 0, 1'b0, 1'b0);
        fb(0, 1'b1, 1'b0);
        cyc("t3.sync0", 8'h02, 1'b1, 1, 1'b0, 1'b0);
        fb(0, 1'b0, 1'b0);
        cyc("t3.none", 8'h00, 1'b0, 1, 1'b0, 1'b0);
        cyc("t3.w1", 8'h02, 1'b1, 1, 1'b0, 1'b0);
        fb(1, 1'b1, 1'b0);
        cyc("t3.sync1", 8'h00, 1'b0, 1, 1'b1, 1'b0);
        fb(0, 1'b0, 1'b0);
        cyc("t3.again0", 8'h01, 1'b1, 0, 1'b0, 1'b0);
        cyc("t3.again1", 8'h02, 1'b1, 1, 1'b0, 1'b0);

        // Exit of the last non-barrier warp releases the barrier
        do_reset();
        launch = 1'b1; launchMask = 8'h07;
        cyc("t4.launch", 8'h00, 1'b0, 0, 1'b0, 1'b0);
        launch = 1'b0;
        cyc("t4.s0", 8'h01, 1'b1, 0, 1'b0, 1'b0);
        fb(0, 1'b1, 1'b0);
        cyc("t4.sync0", 8'h02, 1'b1, 1, 1'b0, 1'b0);
        fb(1, 1'b1, 1'b0);
        cyc("t4.sync1", 8'h04, 1'b1, 2, 1'b0, 1'b0);
        fb(2, 1'b0, 1'b1);
        cyc("t4.exit2", 8'h00, 1'b0, 2, 1'b1, 1'b0);
        fb(0, 1'b0, 1'b0);
        cyc("t4.w0", 8'h01, 1'b1, 0, 1'b0, 1'b0);
        fb(0, 1'b0, 1'b1);
        cyc("t4.exit0", 8'h02, 1'b1, 1, 1'b0, 1'b0);
        fb(1, 1'b0, 1'b1);
        cyc("t4.exit1", 8'h00, 1'b0, 1, 1'b0, 1'b1);
        fb(0, 1'b0, 1'b0);
        cyc("t4.done", 8'h00, 1'b0, 1, 1'b0, 1'b1);

        // Stall holds the packet and defers warp 5's sync
        do_reset();
        launch = 1'b1; launchMask = 8'h60;
        cyc("t5.launch", 8'h00, 1'b0, 0, 1'b0, 1'b0);
        launch = 1'b0;
        cyc("t5.s5", 8'h20, 1'b1, 5, 1'b0, 1'b0);
        bus.stall_i = 1'b1;
        fb(5, 1'b1, 1'b0);
        cyc("t5.stall0", 8'h00, 1'b1, 5, 1'b0, 1'b0);
        cyc("t5.stall1", 8'h00, 1'b1, 5, 1'b0, 1'b0);
        cyc("t5.stall2", 8'h00, 1'b1, 5, 1'b0, 1'b0);
        bus.stall_i = 1'b0;
        cyc("t5.unstall", 8'h40, 1'b1, 6, 1'b0, 1'b0);
        fb(0, 1'b0, 1'b0);
        cyc("t5.bar5", 8'h00, 1'b0, 6, 1'b0, 1'b0);
        cyc("t5.s6", 8'h40, 1'b1, 6, 1'b0, 1'b0);

        // Asynchronous reset mid-run
        #2;
        reset = 1'b0;
        #1;
        chk("t6.vld",  64'(bus.selectedPacketValid_o), 64'd0);
        chk("t6.allx", 64'(allExited), 64'd1);
        chk("t6.pop",  64'(bus.ibufPop_o), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        launch = 1'b1; launchMask = 8'hC1;
        cyc("t6.launch", 8'h00, 1'b0, 0, 1'b0, 1'b0);
        launch = 1'b0;
        cyc("t6.first", 8'h01, 1'b1, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
